// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
// Divide values assume the 100 MHz board clock.
package clk_div_pkg;

    localparam int          CNT_W       = 26;
    localparam int unsigned DEFAULT_DIV = 500000;
    localparam int unsigned DIV_100HZ   = 499999;
    localparam int unsigned DIV_1HZ     = 49999999;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divide registers and output flops.
// A written value waits in the pending register until the next terminal count or SyncIn.
module clk_div_chan #(
    parameter int          CNT_W       = clk_div_pkg::CNT_W,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             SyncIn,
    input  logic             Wr,
    input  logic [CNT_W-1:0] WrDiv,
    output logic             ClkOut,
    output logic             Tick,
    output logic             PendOut
);

    import clk_div_pkg::*;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend;
    logic             pend_valid;

    assign PendOut = pend_valid;

    // The write is evaluated after the apply step so that a write landing on a
    // TC or SyncIn cycle is captured as the next pending value, never lost.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt        <= '0;
            div        <= CNT_W'(DEFAULT_DIV);
            pend       <= '0;
            pend_valid <= 1'b0;
            ClkOut     <= 1'b0;
            Tick       <= 1'b0;
        end else begin
            if (En && SyncIn) begin
                cnt    <= '0;
                ClkOut <= 1'b0;
                Tick   <= 1'b0;
                if (pend_valid) begin
                    div        <= pend;
                    pend_valid <= 1'b0;
                end
            end else if (!En) begin
                cnt    <= '0;
                ClkOut <= 1'b0;
                Tick   <= 1'b0;
            end else if (cnt == div) begin
                cnt    <= '0;
                ClkOut <= ~ClkOut;
                Tick   <= 1'b1;
                if (pend_valid) begin
                    div        <= pend;
                    pend_valid <= 1'b0;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                Tick <= 1'b0;
            end

            if (Wr) begin
                if (En) begin
                    pend       <= WrDiv;
                    pend_valid <= 1'b1;
                end else begin
                    div        <= WrDiv;
                    pend_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes the write channel and
// replicates one clk_div_chan per output.
module clk_div_multi #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = clk_div_pkg::CNT_W,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NUM_CH-1:0] En,
    input  logic              SyncIn,
    input  logic              WrEn,
    input  logic [CH_W-1:0]   WrCh,
    input  logic [CNT_W-1:0]  WrDiv,
    output logic [NUM_CH-1:0] ClkOut,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] PendOut
);

    import clk_div_pkg::*;

    logic [NUM_CH-1:0] wr_sel;

    // Channel numbers at or beyond NUM_CH match no decode line, so such writes vanish.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = WrEn && (WrCh == CH_W'(i));

        clk_div_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .Clk    (Clk),
            .Rst    (Rst),
            .En     (En[i]),
            .SyncIn (SyncIn),
            .Wr     (wr_sel[i]),
            .WrDiv  (WrDiv),
            .ClkOut (ClkOut[i]),
            .Tick   (Tick[i]),
            .PendOut(PendOut[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random traffic, all checked
// against a half-period based reference model of every channel.
module tb_clk_div_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DEF = 3;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [NCH-1:0] En;
    logic           SyncIn;
    logic           WrEn;
    logic [1:0]     WrCh;
    logic [CW-1:0]  WrDiv;
    logic [NCH-1:0] ClkOut;
    logic [NCH-1:0] Tick;
    logic [NCH-1:0] PendOut;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: elapsed cycles in the current half-period, the active
    // divide value and an optional pending value.
    int mDiv[NCH];
    int mElapsed[NCH];
    int mPend[NCH];
    bit mPendValid[NCH];
    bit mLevel[NCH];
    bit mTick[NCH];

    clk_div_multi #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .DEFAULT_DIV(DEF)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .En     (En),
        .SyncIn (SyncIn),
        .WrEn   (WrEn),
        .WrCh   (WrCh),
        .WrDiv  (WrDiv),
        .ClkOut (ClkOut),
        .Tick   (Tick),
        .PendOut(PendOut)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst, input logic [NCH-1:0] en, input bit sync,
                             input bit wen, input int wch, input int wdiv);
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                mDiv[c] = DEF; mElapsed[c] = 0; mPend[c] = 0;
                mPendValid[c] = 0; mLevel[c] = 0; mTick[c] = 0;
                continue;
            end
            if (en[c] && sync) begin
                mElapsed[c] = 0; mLevel[c] = 0; mTick[c] = 0;
                if (mPendValid[c]) begin mDiv[c] = mPend[c]; mPendValid[c] = 0; end
            end else if (!en[c]) begin
                mElapsed[c] = 0; mLevel[c] = 0; mTick[c] = 0;
            end else begin
                mElapsed[c]++;
                if (mElapsed[c] == mDiv[c] + 1) begin
                    mLevel[c] = !mLevel[c];
                    mTick[c] = 1;
                    mElapsed[c] = 0;
                    if (mPendValid[c]) begin mDiv[c] = mPend[c]; mPendValid[c] = 0; end
                end else begin
                    mTick[c] = 0;
                end
            end
            if (wen && wch == c) begin
                if (en[c]) begin mPend[c] = wdiv; mPendValid[c] = 1; end
                else begin mDiv[c] = wdiv; mPendValid[c] = 0; end
            end
        end
    endtask

    // Drive one cycle of inputs, advance both DUT and model, then compare.
    task automatic applyStimulus(input bit rst, input logic [NCH-1:0] en, input bit sync,
                                 input bit wen, input int wch, input int wdiv);
        logic [NCH-1:0] expClk, expTick, expPend;
        Rst = rst; En = en; SyncIn = sync; WrEn = wen;
        WrCh = 2'(wch); WrDiv = CW'(wdiv);
        @(posedge Clk);
        modelStep(rst, en, sync, wen, wch, wdiv);
        #1;
        for (int c = 0; c < NCH; c++) begin
            expClk[c] = mLevel[c]; expTick[c] = mTick[c]; expPend[c] = mPendValid[c];
        end
        checkOutput("ClkOut", 32'(ClkOut), 32'(expClk));
        checkOutput("Tick", 32'(Tick), 32'(expTick));
        checkOutput("PendOut", 32'(PendOut), 32'(expPend));
    endtask

    initial begin
        int riseA, riseB, guard;
        logic [NCH-1:0] rEn;

        Rst = 1'b1; En = '0; SyncIn = 1'b0; WrEn = 1'b0; WrCh = '0; WrDiv = '0;

        // Reset state
        applyStimulus(1, 3'b000, 0, 0, 0, 0);
        applyStimulus(1, 3'b000, 0, 0, 0, 0);
        checkOutput("resetOutputs", 32'({ClkOut, Tick, PendOut}), 32'h0);

        // Free-run channel 0 at the default divide: first rise on edge 4, period 8
        riseA = 0;
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(0, 3'b001, 0, 0, 0, 0);
            if (ClkOut[0] && riseA == 0) riseA = k;
        end
        checkOutput("firstRise", riseA, 4);
        checkOutput("idleChannels", 32'(ClkOut[2:1]), 32'h0);

        // Disabled write goes straight in; Div=0 toggles every cycle
        applyStimulus(0, 3'b001, 0, 1, 1, 0);
        checkOutput("disabledPend", 32'(PendOut[1]), 32'h0);
        applyStimulus(0, 3'b001, 0, 1, 2, 5);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(0, 3'b011, 0, 0, 0, 0);
            checkOutput("div0Tick", 32'(Tick[1]), 32'h1);
            checkOutput("div0Level", 32'(ClkOut[1]), 32'(k % 2));
        end

        // SyncIn alignment of ch0 (Div=3) and ch2 (Div=5)
        for (int k = 0; k < 9; k++) applyStimulus(0, 3'b101, 0, 0, 0, 0);
        applyStimulus(0, 3'b101, 1, 0, 0, 0);
        checkOutput("syncZero", 32'({ClkOut[2], ClkOut[0]}), 32'h0);
        riseA = 0; riseB = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 3'b101, 0, 0, 0, 0);
            if (ClkOut[0] && riseA == 0) riseA = k;
            if (ClkOut[2] && riseB == 0) riseB = k;
        end
        checkOutput("syncRise0", riseA, 4);
        checkOutput("syncRise2", riseB, 6);

        // Glitch-free rewrite to Div=1 two cycles after a TC
        guard = 0;
        while (!Tick[0] && guard < 20) begin
            applyStimulus(0, 3'b001, 0, 0, 0, 0);
            guard++;
        end
        checkOutput("tickWait", 32'(Tick[0]), 32'h1);
        applyStimulus(0, 3'b001, 0, 0, 0, 0);
        applyStimulus(0, 3'b001, 0, 1, 0, 1);
        checkOutput("rewritePend", 32'(PendOut[0]), 32'h1);
        for (int k = 0; k < 12; k++) applyStimulus(0, 3'b001, 0, 0, 0, 0);

        // Write colliding with TC while Pend=7 is waiting
        applyStimulus(0, 3'b001, 0, 1, 0, 7);
        guard = 0;
        while (mElapsed[0] != mDiv[0] && guard < 20) begin
            applyStimulus(0, 3'b001, 0, 0, 0, 0);
            guard++;
        end
        applyStimulus(0, 3'b001, 0, 1, 0, 2);
        checkOutput("collideTick", 32'(Tick[0]), 32'h1);
        checkOutput("collidePend", 32'(PendOut[0]), 32'h1);
        for (int k = 0; k < 20; k++) applyStimulus(0, 3'b001, 0, 0, 0, 0);

        // Rst with a simultaneous write, then default divide again
        applyStimulus(1, 3'b111, 1, 1, 0, 6);
        checkOutput("rstOutputs", 32'({ClkOut, Tick, PendOut}), 32'h0);
        applyStimulus(0, 3'b000, 0, 1, 3, 0);
        riseA = 0;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(0, 3'b111, 0, 0, 0, 0);
            if (ClkOut[0] && riseA == 0) riseA = k;
        end
        checkOutput("rstDefaultRise", riseA, 4);
        checkOutput("outOfRangeCh1", 32'(ClkOut[1]), 32'h1);

        // Random traffic
        rEn = 3'b111;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) rEn = 3'($urandom);
            applyStimulus($urandom_range(0, 99) == 0, rEn,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 6) == 0,
                          $urandom_range(0, 3), $urandom_range(0, 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
